// File: rtl/turn_ctl.sv
// turn_ctl: turn sequencer for a two-player cat/dog throwing game.
// Owns the game tick, throw-force charging, flight timeout, HP bookkeeping and game end.
module turn_ctl #(
    parameter int TICK_DIV     = 65000,
    parameter int FORCE_STEP   = 4,
    parameter int FORCE_MAX    = 1000,
    parameter int FLIGHT_TICKS = 3000,
    parameter int SETTLE_TICKS = 2,
    parameter int HP_INIT      = 100,
    parameter int DAMAGE       = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       btn_throw,
    input  logic       hit_cat,
    input  logic       hit_dog,
    output logic       enable_cat,
    output logic       enable_dog,
    output logic [9:0] throw_force,
    output logic       turn,
    output logic [6:0] hp_cat,
    output logic [6:0] hp_dog,
    output logic       game_over,
    output logic       winner
);

    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FLIGHT_W = $clog2(FLIGHT_TICKS + 1);
    localparam int SETTLE_W = $clog2(SETTLE_TICKS + 1);

    localparam logic [TICK_W-1:0]   TICK_LAST   = TICK_W'(TICK_DIV - 1);
    localparam logic [FLIGHT_W-1:0] FLIGHT_LAST = FLIGHT_W'(FLIGHT_TICKS - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_TICKS - 1);
    localparam logic [10:0]         FORCE_INC   = 11'(FORCE_STEP);
    localparam logic [10:0]         FORCE_CAP   = 11'(FORCE_MAX);
    localparam logic [6:0]          HP_START    = 7'(HP_INIT);
    localparam logic [6:0]          HP_DAMAGE   = 7'(DAMAGE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READY,
        S_CHARGE,
        S_THROW,
        S_SETTLE,
        S_OVER
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [TICK_W-1:0]   r_tick_cnt;
    logic [FLIGHT_W-1:0] r_flight_cnt;
    logic [SETTLE_W-1:0] r_settle_cnt;
    logic [9:0]          r_force;
    logic [6:0]          r_hp_cat;
    logic [6:0]          r_hp_dog;
    logic                r_turn;
    logic                r_game_over;
    logic                r_winner;
    logic                r_en_cat;
    logic                r_en_dog;
    logic                r_btn_prev;

    logic        w_tick;
    logic        w_btn_rise;
    logic        w_hit_active;
    logic        w_opp_hp_zero;
    logic        w_flight_done;
    logic        w_settle_done;
    logic [10:0] w_force_sum;
    logic [9:0]  w_force_next;
    logic [6:0]  w_hp_cat_dec;
    logic [6:0]  w_hp_dog_dec;

    logic w_load_game;
    logic w_clr_force;
    logic w_add_force;
    logic w_apply_hit;
    logic w_toggle_turn;
    logic w_end_game;

    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || w_tick) r_tick_cnt <= '0;
        else               r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end

    assign w_tick        = (r_tick_cnt == TICK_LAST);
    assign w_btn_rise    = btn_throw & ~r_btn_prev;
    assign w_hit_active  = r_turn ? hit_dog : hit_cat;
    assign w_opp_hp_zero = r_turn ? (r_hp_cat == '0) : (r_hp_dog == '0);
    assign w_flight_done = w_tick && (r_flight_cnt == FLIGHT_LAST);
    assign w_settle_done = w_tick && (r_settle_cnt == SETTLE_LAST);

    // 11-bit sum so a step near the 10-bit ceiling saturates instead of wrapping.
    assign w_force_sum  = {1'b0, r_force} + FORCE_INC;
    assign w_force_next = (w_force_sum >= FORCE_CAP) ? FORCE_CAP[9:0] : w_force_sum[9:0];
    assign w_hp_cat_dec = (r_hp_cat <= HP_DAMAGE) ? 7'd0 : r_hp_cat - HP_DAMAGE;
    assign w_hp_dog_dec = (r_hp_dog <= HP_DAMAGE) ? 7'd0 : r_hp_dog - HP_DAMAGE;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state  = r_state;
        w_load_game   = 1'b0;
        w_clr_force   = 1'b0;
        w_add_force   = 1'b0;
        w_apply_hit   = 1'b0;
        w_toggle_turn = 1'b0;
        w_end_game    = 1'b0;
        case (r_state)
            S_IDLE, S_OVER: begin
                if (start) begin
                    w_load_game  = 1'b1;
                    w_next_state = S_READY;
                end
            end
            S_READY: begin
                if (w_btn_rise) begin
                    w_clr_force  = 1'b1;
                    w_next_state = S_CHARGE;
                end
            end
            S_CHARGE: begin
                if (!btn_throw) w_next_state = S_THROW;
                else if (w_tick) w_add_force = 1'b1;
            end
            S_THROW: begin
                // A hit beats a timeout landing on the same edge.
                if (w_hit_active) begin
                    w_apply_hit  = 1'b1;
                    w_next_state = S_SETTLE;
                end else if (w_flight_done) begin
                    w_next_state = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (w_settle_done) begin
                    if (w_opp_hp_zero) begin
                        w_end_game   = 1'b1;
                        w_next_state = S_OVER;
                    end else begin
                        w_toggle_turn = 1'b1;
                        w_next_state  = S_READY;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flight_cnt <= '0;
            r_settle_cnt <= '0;
            r_force      <= '0;
            r_hp_cat     <= HP_START;
            r_hp_dog     <= HP_START;
            r_turn       <= 1'b0;
            r_game_over  <= 1'b0;
            r_winner     <= 1'b0;
            r_en_cat     <= 1'b0;
            r_en_dog     <= 1'b0;
            r_btn_prev   <= 1'b0;
        end else begin
            r_btn_prev <= btn_throw;

            if (r_state != w_next_state) begin
                r_flight_cnt <= '0;
                r_settle_cnt <= '0;
            end else if (w_tick) begin
                if (r_state == S_THROW)  r_flight_cnt <= r_flight_cnt + FLIGHT_W'(1);
                if (r_state == S_SETTLE) r_settle_cnt <= r_settle_cnt + SETTLE_W'(1);
            end

            if (w_clr_force)      r_force <= '0;
            else if (w_add_force) r_force <= w_force_next;

            if (w_load_game) begin
                r_hp_cat    <= HP_START;
                r_hp_dog    <= HP_START;
                r_turn      <= 1'b0;
                r_game_over <= 1'b0;
            end

            if (w_apply_hit) begin
                if (r_turn) r_hp_cat <= w_hp_cat_dec;
                else        r_hp_dog <= w_hp_dog_dec;
            end

            if (w_toggle_turn) r_turn <= ~r_turn;

            if (w_end_game) begin
                r_game_over <= 1'b1;
                r_winner    <= r_turn;
            end

            // Turn never changes while entering THROW, so the enables follow the state edge only.
            r_en_cat <= (w_next_state == S_THROW) && !r_turn;
            r_en_dog <= (w_next_state == S_THROW) &&  r_turn;
        end
    end

    assign enable_cat  = r_en_cat;
    assign enable_dog  = r_en_dog;
    assign throw_force = r_force;
    assign turn        = r_turn;
    assign hp_cat      = r_hp_cat;
    assign hp_dog      = r_hp_dog;
    assign game_over   = r_game_over;
    assign winner      = r_winner;

endmodule

// File: tb/tb_turn_ctl.sv
// tb_turn_ctl: directed-vector bench for turn_ctl with a small tick-phase model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_turn_ctl;

    localparam int TICK_DIV     = 4;
    localparam int FLIGHT_TICKS = 10;
    localparam int SETTLE_TICKS = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       btn_throw;
    logic       hit_cat;
    logic       hit_dog;
    logic       enable_cat;
    logic       enable_dog;
    logic [9:0] throw_force;
    logic       turn;
    logic [6:0] hp_cat;
    logic [6:0] hp_dog;
    logic       game_over;
    logic       winner;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    turn_ctl #(
        .TICK_DIV    (TICK_DIV),
        .FORCE_STEP  (4),
        .FORCE_MAX   (1000),
        .FLIGHT_TICKS(FLIGHT_TICKS),
        .SETTLE_TICKS(SETTLE_TICKS),
        .HP_INIT     (40),
        .DAMAGE      (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .btn_throw  (btn_throw),
        .hit_cat    (hit_cat),
        .hit_dog    (hit_dog),
        .enable_cat (enable_cat),
        .enable_dog (enable_dog),
        .throw_force(throw_force),
        .turn       (turn),
        .hp_cat     (hp_cat),
        .hp_dog     (hp_dog),
        .game_over  (game_over),
        .winner     (winner)
    );

    always #5 clk = ~clk;

    // Posedges since reset release; the tick falls on every TICK_DIV-th one.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic bit next_is_tick();
        return (cyc % TICK_DIV) == (TICK_DIV - 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Stop on the falling edge just before the n-th upcoming tick edge.
    task automatic to_tick(input int n);
        int seen = 0;
        while (1) begin
            if (next_is_tick()) begin
                seen++;
                if (seen == n) break;
            end
            @(negedge clk);
        end
    endtask

    task automatic charge(input int posedges);
        btn_throw = 1'b1;
        repeat (posedges) @(negedge clk);
        btn_throw = 1'b0;
        @(negedge clk);
    endtask

    task automatic settle_out();
        to_tick(SETTLE_TICKS);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; btn_throw = 1'b0; hit_cat = 1'b0; hit_dog = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_en_cat", 32'(enable_cat), 0);
        check("reset_en_dog", 32'(enable_dog), 0);
        check("reset_force", 32'(throw_force), 0);
        check("reset_turn", 32'(turn), 0);
        check("reset_hp_cat", 32'(hp_cat), 40);
        check("reset_hp_dog", 32'(hp_dog), 40);
        check("reset_game_over", 32'(game_over), 0);
        check("reset_winner", 32'(winner), 0);

        // Button held through IDLE and into READY must not launch a throw.
        btn_throw = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        btn_throw = 1'b0;
        repeat (2) @(negedge clk);
        check("held_btn_no_throw", 32'(enable_cat), 0);

        // A: cat charges 5 ticks (20 charge edges), hits the dog.
        btn_throw = 1'b1;
        @(negedge clk);
        repeat (20) @(negedge clk);
        check("charge_force_5_ticks", 32'(throw_force), 20);
        btn_throw = 1'b0;
        @(negedge clk);
        check("a_force", 32'(throw_force), 20);
        check("a_en_cat", 32'(enable_cat), 1);
        check("a_en_dog", 32'(enable_dog), 0);
        check("a_turn", 32'(turn), 0);
        hit_dog = 1'b1;
        @(negedge clk);
        hit_dog = 1'b0;
        check("a_ignore_hit_dog_en", 32'(enable_cat), 1);
        check("a_ignore_hit_dog_hp", 32'(hp_cat), 40);
        hit_cat = 1'b1;
        @(negedge clk);
        hit_cat = 1'b0;
        check("a_hit_hp_dog", 32'(hp_dog), 20);
        check("a_hit_en_cat", 32'(enable_cat), 0);
        to_tick(SETTLE_TICKS);
        check("a_settle_turn_hold", 32'(turn), 0);
        @(negedge clk);
        check("a_turn_toggle", 32'(turn), 1);

        // B: dog charges 300 ticks, force saturates, flight times out.
        btn_throw = 1'b1;
        @(negedge clk);
        check("b_ready_force_clear", 32'(throw_force), 0);
        repeat (1200) @(negedge clk);
        check("b_force_saturate", 32'(throw_force), 1000);
        btn_throw = 1'b0;
        @(negedge clk);
        check("b_en_dog", 32'(enable_dog), 1);
        check("b_en_cat", 32'(enable_cat), 0);
        check("b_force_hold", 32'(throw_force), 1000);
        to_tick(FLIGHT_TICKS);
        check("b_en_before_timeout", 32'(enable_dog), 1);
        @(negedge clk);
        check("b_en_after_timeout", 32'(enable_dog), 0);
        check("b_timeout_hp_cat", 32'(hp_cat), 40);
        check("b_timeout_hp_dog", 32'(hp_dog), 20);
        settle_out();
        check("b_turn_toggle", 32'(turn), 0);

        // C: cat one-tick charge, timeout, turn passes to the dog.
        charge(5);
        check("c_force_1_tick", 32'(throw_force), 4);
        to_tick(FLIGHT_TICKS);
        @(negedge clk);
        settle_out();
        check("c_turn_toggle", 32'(turn), 1);
        check("c_hp_dog_unchanged", 32'(hp_dog), 20);

        // D: dog throw; cat's hit pulse ignored, dog's hit lands.
        charge(9);
        check("d_en_dog", 32'(enable_dog), 1);
        hit_cat = 1'b1;
        @(negedge clk);
        hit_cat = 1'b0;
        check("d_ignore_hit_cat_en", 32'(enable_dog), 1);
        check("d_ignore_hit_cat_hp", 32'(hp_cat), 40);
        hit_dog = 1'b1;
        @(negedge clk);
        hit_dog = 1'b0;
        check("d_hit_hp_cat", 32'(hp_cat), 20);
        check("d_hit_en_dog", 32'(enable_dog), 0);
        settle_out();
        check("d_turn_toggle", 32'(turn), 0);

        // E: cat hit coincides with the timeout tick; dog HP hits zero.
        charge(5);
        check("e_en_cat", 32'(enable_cat), 1);
        to_tick(FLIGHT_TICKS);
        hit_cat = 1'b1;
        @(negedge clk);
        hit_cat = 1'b0;
        check("e_coincident_hp_dog", 32'(hp_dog), 0);
        check("e_en_cat_low", 32'(enable_cat), 0);
        check("e_not_over_yet", 32'(game_over), 0);
        settle_out();
        check("e_game_over", 32'(game_over), 1);
        check("e_winner", 32'(winner), 0);
        check("e_turn_held", 32'(turn), 0);

        // F: button ignored in OVER, then start reloads the game.
        btn_throw = 1'b1;
        repeat (6) @(negedge clk);
        btn_throw = 1'b0;
        repeat (2) @(negedge clk);
        check("f_over_en_cat", 32'(enable_cat), 0);
        check("f_over_en_dog", 32'(enable_dog), 0);
        check("f_over_force_hold", 32'(throw_force), 4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("f_restart_hp_cat", 32'(hp_cat), 40);
        check("f_restart_hp_dog", 32'(hp_dog), 40);
        check("f_restart_turn", 32'(turn), 0);
        check("f_restart_over", 32'(game_over), 0);

        // G: cat hit, then reset in the middle of the dog's throw.
        charge(5);
        hit_cat = 1'b1;
        @(negedge clk);
        hit_cat = 1'b0;
        check("g_hp_dog", 32'(hp_dog), 20);
        settle_out();
        check("g_turn", 32'(turn), 1);
        charge(5);
        check("g_en_dog", 32'(enable_dog), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("g_rst_en_dog", 32'(enable_dog), 0);
        check("g_rst_en_cat", 32'(enable_cat), 0);
        check("g_rst_force", 32'(throw_force), 0);
        check("g_rst_turn", 32'(turn), 0);
        check("g_rst_hp_dog", 32'(hp_dog), 40);
        check("g_rst_hp_cat", 32'(hp_cat), 40);
        check("g_rst_over", 32'(game_over), 0);
        check("g_rst_winner", 32'(winner), 0);
        rst = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
